// File: rtl/game_flow_fsm_if.sv
// Signal bundle between the game-flow controller and its neighbours:
// joystick/score/frame inputs toward the controller, state decodes,
// clock-enables, game reset, cursor, countdown and winner back out.
interface game_flow_fsm_if #(
    parameter int SCORE_WIDTH = 4,
    parameter int CNT_WIDTH   = 2
);
    logic                   enter;
    logic                   up;
    logic                   down;
    logic                   frame_tick;
    logic [SCORE_WIDTH-1:0] score_left;
    logic [SCORE_WIDTH-1:0] score_right;

    logic                   enable_start;
    logic                   enable_countdown;
    logic                   enable_game;
    logic                   enable_pause;
    logic                   enable_over;
    logic                   game_ce;
    logic                   menu_ce;
    logic                   game_reset;
    logic [1:0]             cursor;
    logic [CNT_WIDTH-1:0]   countdown;
    logic                   winner;

    // Joystick/score side drives the inputs and observes the controller.
    modport master (
        output enter, up, down, frame_tick, score_left, score_right,
        input  enable_start, enable_countdown, enable_game, enable_pause,
               enable_over, game_ce, menu_ce, game_reset, cursor,
               countdown, winner
    );

    // The controller itself.
    modport slave (
        input  enter, up, down, frame_tick, score_left, score_right,
        output enable_start, enable_countdown, enable_game, enable_pause,
               enable_over, game_ce, menu_ce, game_reset, cursor,
               countdown, winner
    );
endinterface

// File: rtl/game_flow_fsm.sv
// Pong game-flow controller: START -> COUNTDOWN -> GAME <-> PAUSE -> GAME_OVER.
// Owns the pause-menu cursor, detects a win from the scores, and emits a
// one-cycle active-low game reset plus clock-enables for core and menus.
module game_flow_fsm #(
    parameter int SCORE_WIDTH      = 4,
    parameter int WIN_SCORE        = 7,
    parameter int COUNTDOWN_FRAMES = 3,
    parameter int CNT_WIDTH        = 2
) (
    input  logic            clock,
    input  logic            reset,
    game_flow_fsm_if.slave  bus
);

    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_GAME      = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_OVER      = 3'd4;

    localparam logic [1:0] CUR_CONTINUE = 2'd0;
    localparam logic [1:0] CUR_RESTART  = 2'd1;
    localparam logic [1:0] CUR_QUIT     = 2'd2;

    localparam logic [CNT_WIDTH-1:0]   CNT_LOAD  = CNT_WIDTH'(COUNTDOWN_FRAMES);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] WIN_LEVEL = SCORE_WIDTH'(WIN_SCORE);

    logic [2:0]           state_q,      state_d;
    logic [1:0]           cursor_q,     cursor_d;
    logic [CNT_WIDTH-1:0] countdown_q,  countdown_d;
    logic                 winner_q,     winner_d;
    logic                 game_reset_q, game_reset_d;
    logic                 enter_q,      enter_d;
    logic                 up_q,         up_d;
    logic                 down_q,       down_d;

    logic enter_e, up_e, down_e;
    logic left_win, right_win;
    logic reset_req;

    assign enter_e   = bus.enter & ~enter_q;
    assign up_e      = bus.up    & ~up_q;
    assign down_e    = bus.down  & ~down_q;
    assign left_win  = (bus.score_left  >= WIN_LEVEL);
    assign right_win = (bus.score_right >= WIN_LEVEL);

    // Next-state, cursor, countdown, winner and game-reset request.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d     = state_q;
        cursor_d    = cursor_q;
        countdown_d = countdown_q;
        winner_d    = winner_q;
        reset_req   = 1'b0;
        enter_d     = bus.enter;
        up_d        = bus.up;
        down_d      = bus.down;

        case (state_q)
            ST_START: begin
                if (enter_e) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CNT_LOAD;
                    reset_req   = 1'b1;
                end
            end

            ST_COUNTDOWN: begin
                // Buttons are deliberately ignored here; only frames count.
                if (bus.frame_tick) begin
                    if (countdown_q <= CNT_ONE) begin
                        state_d     = ST_GAME;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown_q - CNT_ONE;
                    end
                end
            end

            ST_GAME: begin
                // A win outranks a pause request in the same cycle; ties go left.
                if (left_win || right_win) begin
                    state_d  = ST_OVER;
                    winner_d = right_win & ~left_win;
                end else if (enter_e) begin
                    state_d  = ST_PAUSE;
                    cursor_d = CUR_CONTINUE;
                end
            end

            ST_PAUSE: begin
                if (enter_e) begin
                    case (cursor_q)
                        CUR_CONTINUE: begin
                            state_d     = ST_COUNTDOWN;
                            countdown_d = CNT_LOAD;
                        end
                        CUR_RESTART: begin
                            state_d     = ST_COUNTDOWN;
                            countdown_d = CNT_LOAD;
                            reset_req   = 1'b1;
                        end
                        default: state_d = ST_START;
                    endcase
                end else if (up_e && !down_e) begin
                    cursor_d = (cursor_q == CUR_CONTINUE) ? CUR_QUIT : cursor_q - 2'd1;
                end else if (down_e && !up_e) begin
                    cursor_d = (cursor_q == CUR_QUIT) ? CUR_CONTINUE : cursor_q + 2'd1;
                end
            end

            ST_OVER: begin
                if (enter_e) state_d = ST_START;
            end

            default: begin
                // Unreachable encoding: recover to a clean start.
                state_d     = ST_START;
                cursor_d    = CUR_CONTINUE;
                countdown_d = '0;
                reset_req   = 1'b1;
            end
        endcase

        game_reset_d = ~reset_req;
    end

    // State and output registers; edge-detect copies reset high so a
    // button held through reset does not register as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_START;
            cursor_q     <= CUR_CONTINUE;
            countdown_q  <= '0;
            winner_q     <= 1'b0;
            game_reset_q <= 1'b0;
            enter_q      <= 1'b1;
            up_q         <= 1'b1;
            down_q       <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            countdown_q  <= countdown_d;
            winner_q     <= winner_d;
            game_reset_q <= game_reset_d;
            enter_q      <= enter_d;
            up_q         <= up_d;
            down_q       <= down_d;
        end
    end

    assign bus.enable_start     = (state_q == ST_START);
    assign bus.enable_countdown = (state_q == ST_COUNTDOWN);
    assign bus.enable_game      = (state_q == ST_GAME);
    assign bus.enable_pause     = (state_q == ST_PAUSE);
    assign bus.enable_over      = (state_q == ST_OVER);
    assign bus.game_ce          = (state_q == ST_GAME);
    assign bus.menu_ce          = (state_q != ST_GAME);
    assign bus.game_reset       = game_reset_q;
    assign bus.cursor           = cursor_q;
    assign bus.countdown        = countdown_q;
    assign bus.winner           = winner_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm. Each step drives inputs, pushes the
// expected post-edge output snapshot, and pops/compares it after the edge.
module tb_game_flow_fsm;

    localparam int S_START = 0;
    localparam int S_CD    = 1;
    localparam int S_GAME  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_OVER  = 4;

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   passed;
    exp_t sb[$];

    game_flow_fsm_if #(.SCORE_WIDTH(4), .CNT_WIDTH(2)) bus ();

    game_flow_fsm #(
        .SCORE_WIDTH(4), .WIN_SCORE(7), .COUNTDOWN_FRAMES(3), .CNT_WIDTH(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Snapshot: {start,countdown,game,pause,over, game_ce, menu_ce, game_reset, cursor[1:0], countdown[1:0], winner}
    function automatic logic [12:0] observe();
        return {bus.enable_start, bus.enable_countdown, bus.enable_game,
                bus.enable_pause, bus.enable_over, bus.game_ce, bus.menu_ce,
                bus.game_reset, bus.cursor, bus.countdown, bus.winner};
    endfunction

    function automatic logic [12:0] ev(int st, bit gr, int cur, int cd, bit w);
        logic [4:0] oh;
        bit         in_game;
        oh      = 5'b10000 >> st;
        in_game = (st == S_GAME);
        return {oh, in_game, !in_game, gr, 2'(cur), 2'(cd), w};
    endfunction

    task automatic check(string tag, logic [12:0] obs, logic [12:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(), e.val);
        end
    endtask

    // Drive joystick/frame inputs, expect a snapshot after the next edge.
    task automatic step(string tag, bit en, bit u, bit d, bit tick, logic [12:0] exp);
        bus.enter      = en;
        bus.up         = u;
        bus.down       = d;
        bus.frame_tick = tick;
        sb.push_back('{tag, exp});
        @(posedge clock);
        #1;
        drain();
    endtask

    task automatic scores(int l, int r);
        bus.score_left  = 4'(l);
        bus.score_right = 4'(r);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        bus.enter = 1'b0; bus.up = 1'b0; bus.down = 1'b0; bus.frame_tick = 1'b0;
        scores(0, 0);

        #2;
        sb.push_back('{"reset_state", ev(S_START, 0, 0, 0, 0)});
        drain();
        @(negedge clock);
        reset = 1'b1;

        // Start, hold enter across the whole countdown: one press only.
        step("rst_release",   0, 0, 0, 0, ev(S_START, 1, 0, 0, 0));
        step("start_press",   1, 0, 0, 0, ev(S_CD,    0, 0, 3, 0));
        step("cd_hold1",      1, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));
        step("cd_hold2",      1, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));
        step("cd_hold3",      1, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));
        step("cd_hold4",      1, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));
        step("cd_tick1",      1, 0, 0, 1, ev(S_CD,    1, 0, 2, 0));
        step("cd_notick",     1, 0, 0, 0, ev(S_CD,    1, 0, 2, 0));
        step("cd_tick2",      1, 0, 0, 1, ev(S_CD,    1, 0, 1, 0));
        step("cd_tick3",      1, 0, 0, 1, ev(S_GAME,  1, 0, 0, 0));
        step("game_held",     1, 0, 0, 0, ev(S_GAME,  1, 0, 0, 0));
        step("game_release",  0, 0, 0, 0, ev(S_GAME,  1, 0, 0, 0));

        // Pause menu wrap, simultaneous up/down, restart.
        step("pause_enter",   1, 0, 0, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("up_wrap",       0, 1, 0, 0, ev(S_PAUSE, 1, 2, 0, 0));
        step("down_wrap",     0, 0, 1, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("down_release",  0, 0, 0, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("down_to1",      0, 0, 1, 0, ev(S_PAUSE, 1, 1, 0, 0));
        step("idle",          0, 0, 0, 0, ev(S_PAUSE, 1, 1, 0, 0));
        step("up_and_down",   0, 1, 1, 0, ev(S_PAUSE, 1, 1, 0, 0));
        step("idle2",         0, 0, 0, 0, ev(S_PAUSE, 1, 1, 0, 0));
        step("restart",       1, 0, 0, 0, ev(S_CD,    0, 1, 3, 0));

        // Countdown ignores button events.
        step("imm_up",        0, 1, 0, 0, ev(S_CD,    1, 1, 3, 0));
        step("imm_down",      0, 0, 1, 0, ev(S_CD,    1, 1, 3, 0));
        step("imm_enter",     1, 0, 0, 0, ev(S_CD,    1, 1, 3, 0));
        step("cd2_tick1",     0, 0, 0, 1, ev(S_CD,    1, 1, 2, 0));
        step("cd2_tick2",     0, 0, 0, 1, ev(S_CD,    1, 1, 1, 0));
        step("cd2_tick3",     0, 0, 0, 1, ev(S_GAME,  1, 1, 0, 0));

        // Continue: resume without game reset.
        step("pause2",        1, 0, 0, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("pause2_idle",   0, 0, 0, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("continue",      1, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));
        step("cd3_tick1",     0, 0, 0, 1, ev(S_CD,    1, 0, 2, 0));
        step("cd3_tick2",     0, 0, 0, 1, ev(S_CD,    1, 0, 1, 0));
        step("cd3_tick3",     0, 0, 0, 1, ev(S_GAME,  1, 0, 0, 0));

        // Quit back to START.
        step("pause3",        1, 0, 0, 0, ev(S_PAUSE, 1, 0, 0, 0));
        step("to_quit",       0, 1, 0, 0, ev(S_PAUSE, 1, 2, 0, 0));
        step("quit_idle",     0, 0, 0, 0, ev(S_PAUSE, 1, 2, 0, 0));
        step("quit",          1, 0, 0, 0, ev(S_START, 1, 2, 0, 0));

        // New game, then win checks.
        step("start2_idle",   0, 0, 0, 0, ev(S_START, 1, 2, 0, 0));
        step("start2",        1, 0, 0, 0, ev(S_CD,    0, 2, 3, 0));
        step("cd4_tick1",     0, 0, 0, 1, ev(S_CD,    1, 2, 2, 0));
        step("cd4_tick2",     0, 0, 0, 1, ev(S_CD,    1, 2, 1, 0));
        step("cd4_tick3",     0, 0, 0, 1, ev(S_GAME,  1, 2, 0, 0));
        scores(6, 6);
        step("below_win",     0, 0, 0, 0, ev(S_GAME,  1, 2, 0, 0));
        scores(3, 7);
        step("right_wins",    0, 0, 0, 0, ev(S_OVER,  1, 2, 0, 1));
        scores(0, 0);
        step("winner_held",   0, 0, 0, 0, ev(S_OVER,  1, 2, 0, 1));
        step("over_exit",     1, 0, 0, 0, ev(S_START, 1, 2, 0, 1));
        step("start3_idle",   0, 0, 0, 0, ev(S_START, 1, 2, 0, 1));
        step("start3",        1, 0, 0, 0, ev(S_CD,    0, 2, 3, 1));
        step("cd5_tick1",     0, 0, 0, 1, ev(S_CD,    1, 2, 2, 1));
        step("cd5_tick2",     0, 0, 0, 1, ev(S_CD,    1, 2, 1, 1));
        step("cd5_tick3",     0, 0, 0, 1, ev(S_GAME,  1, 2, 0, 1));
        scores(7, 7);
        step("tie_over_pause", 1, 0, 0, 0, ev(S_OVER, 1, 2, 0, 0));
        scores(0, 0);
        step("tie_held",      0, 0, 0, 0, ev(S_OVER,  1, 2, 0, 0));
        step("over_exit2",    1, 0, 0, 0, ev(S_START, 1, 2, 0, 0));
        step("start4_idle",   0, 0, 0, 0, ev(S_START, 1, 2, 0, 0));
        step("start4",        1, 0, 0, 0, ev(S_CD,    0, 2, 3, 0));
        step("cd6_tick1",     0, 0, 0, 1, ev(S_CD,    1, 2, 2, 0));

        // Asynchronous reset between edges, with enter held through it.
        #2;
        bus.enter = 1'b1;
        reset     = 1'b0;
        #1;
        sb.push_back('{"async_reset", ev(S_START, 0, 0, 0, 0)});
        drain();
        @(negedge clock);
        reset = 1'b1;
        step("async_release", 1, 0, 0, 0, ev(S_START, 1, 0, 0, 0));
        step("held_idle",     0, 0, 0, 0, ev(S_START, 1, 0, 0, 0));
        step("fresh_press",   1, 0, 0, 0, ev(S_CD,    0, 0, 3, 0));
        step("fresh_after",   0, 0, 0, 0, ev(S_CD,    1, 0, 3, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_flow_fsm.md
# game_flow_fsm

Top-level game-flow controller for Pong and the successor to the current start/game/pause controller. It sequences START → COUNTDOWN → GAME ↔ PAUSE → GAME_OVER, and owns the pause-menu cursor. It uses edge-detected joystick inputs, detects a win from the score inputs, and issues one-cycle active-low game-reset pulses. It drives clock-enables instead of gated clocks, and sits between the joystick/score logic and the renderer and game core.

## Interface
- SCORE_WIDTH, 4: width of each score input.
- WIN_SCORE, 7: score at or above which a player wins; must be in 1..2^SCORE_WIDTH-1.
- COUNTDOWN_FRAMES, 3: number of frame_tick pulses spent in COUNTDOWN; must be ≥1.
- CNT_WIDTH, 2: countdown counter width; must hold COUNTDOWN_FRAMES.
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enter  in  1  joystick button, level, synchronous to clock.
- up  in  1  joystick up, level, synchronous.
- down  in  1  joystick down, level, synchronous.
- frame_tick  in  1  one-cycle pulse per video frame.
- score_left  in  SCORE_WIDTH  left player score.
- score_right  in  SCORE_WIDTH  right player score.
- enable_start, enable_countdown, enable_game, enable_pause, enable_over  out  1 each  one-hot state decode.
- game_ce  out  1  clock-enable for the game core; equals enable_game.
- menu_ce  out  1  clock-enable for the menus; equals ~enable_game.
- game_reset  out  1  active-low reset pulse to the game core.
- cursor  out  2  pause-menu selection: 0 Continue, 1 Restart, 2 Quit.
- countdown  out  CNT_WIDTH  frames remaining in COUNTDOWN; 0 in all other states.
- winner  out  1  0 = left, 1 = right; valid while enable_over.

## Operation
- **Edge detection**
  - Registered copies enter_q, up_q and down_q are kept.
  - Events are enter_e = enter & ~enter_q, and likewise up_e and down_e.
  - A held button produces exactly one event.
- **START**
  - enter_e → COUNTDOWN, load countdown = COUNTDOWN_FRAMES, pulse game_reset.
- **COUNTDOWN**
  - Each frame_tick decrements countdown.
  - A frame_tick while countdown == 1 → GAME, countdown = 0.
  - enter_e, up_e and down_e are ignored.
- **GAME**
  - Win check: score_left ≥ WIN_SCORE or score_right ≥ WIN_SCORE → GAME_OVER.
  - winner = 1 only if score_right ≥ WIN_SCORE and score_left < WIN_SCORE; a simultaneous win goes to left.
  - The win check has priority over enter_e in the same cycle.
  - Otherwise enter_e → PAUSE, cursor = 0.
- **PAUSE**
  - down_e: cursor 0→1→2→0 (wraps).
  - up_e: cursor 0→2→1→0 (wraps).
  - up_e and down_e in the same cycle: cursor unchanged.
  - enter_e acts on the current cursor and ignores same-cycle up_e/down_e.
    - Cursor 0: → COUNTDOWN (resume; no game_reset).
    - Cursor 1: → COUNTDOWN with a game_reset pulse.
    - Cursor 2: → START.
  - countdown is reloaded on every entry to COUNTDOWN.
- **GAME_OVER**
  - enter_e → START.
  - winner is held until the next entry to GAME_OVER.
- **Illegal state encoding:** → START with a game_reset pulse.
- **game_reset**
  - Driven low for exactly one cycle: the cycle after the transition edge that requests it.
  - High otherwise.

## Timing
- **Reset values while reset is low:**
  - state START: enable_start = 1, other enables 0.
  - game_ce = 0, menu_ce = 1.
  - game_reset = 0.
  - cursor = 0, countdown = 0, winner = 0.
  - enter_q = up_q = down_q = 1, so a button held through reset is not an event.
- **After reset release:** game_reset rises to 1 on the first clock edge.
- **Transition latency:** an input event sampled at edge N changes state, enables, cursor and countdown from edge N (visible in cycle N+1). game_reset is low in that same cycle N+1 only.
- **Enable outputs and clock-enables:**
  - Enables are pure decodes of the state register, so they are glitch-free.
  - game_ce and menu_ce are never both 1 or both 0.
- **COUNTDOWN duration:** exactly COUNTDOWN_FRAMES frame_tick pulses, independent of the clock-to-frame ratio.
- **Reset mid-operation:** asserting reset in any state forces the reset values immediately, without waiting for a clock edge.

## Test plan
- **Start and countdown:** reset, release, hold enter for 5 cycles, give 3 frame_ticks → exactly one game_reset low cycle; countdown reads 3, 2, 1, 0; enable_game after the 3rd tick; no further transitions while enter stays held.
- **Pause menu wrap:** in PAUSE, up_e once → cursor 2; down_e ×2 → cursor 1; up and down together → cursor stays 1; enter_e → COUNTDOWN with a game_reset pulse.
- **Continue and quit:** cursor 0 + enter_e → COUNTDOWN without game_reset, then GAME. Cursor 2 + enter_e → START, enable_start = 1.
- **Win detection:** in GAME, score_right = 7 with score_left = 3 → GAME_OVER, winner = 1. Both scores 7 in the same cycle as enter_e → GAME_OVER, winner = 0, no PAUSE.
- **Countdown immunity:** enter/up/down pulses during COUNTDOWN → no state or cursor change.
- **Async reset:** assert reset mid-COUNTDOWN, between clock edges → immediate enable_start = 1, countdown = 0, game_reset = 0; after release, game_reset = 1 on the next edge.
